// File: rtl/disp_pkg.sv
// Shared definitions for the display scheduler: state encoding, default timing
// parameters and the two-requester round-robin pick.
package disp_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    MSG    = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam int DEF_TICK_DIV = 100000;
  localparam int DEF_HOLD_MS  = 2000;
  localparam int DEF_GAP_MS   = 100;
  localparam int FLASH_MS     = 250;

  // One-hot winner; on a tie the requester not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

endpackage

// File: rtl/disp_sched_ms_tick_gen.sv
// Free-running 1 ms prescaler: counts 0..TICK_DIV-1 and flags the last count.
module ms_tick_gen
  import disp_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (cnt_reg == W'(TICK_DIV - 1))
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + W'(1);
  end

  assign tick = (cnt_reg == W'(TICK_DIV - 1));

endmodule

// File: rtl/disp_sched.sv
// Display scheduler: live score/time, interrupted by arbitrated timed messages
// followed by a blank gap. Define DISP_SCHED_FLASH_EN to flash messages.
module disp_sched
  import disp_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int HOLD_MS  = DEF_HOLD_MS,
  parameter int GAP_MS   = DEF_GAP_MS
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [31:0] score,
  input  logic [31:0] total_time,
  input  logic [1:0]  req,
  input  logic [31:0] msg0_score,
  input  logic [31:0] msg0_time,
  input  logic [31:0] msg1_score,
  input  logic [31:0] msg1_time,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [31:0] disp_score,
  output logic [31:0] disp_time,
  output logic        blank
);

  state_t      state_reg;
  logic [15:0] ms_cnt_reg;
  logic        last_reg;
  logic        owner_reg;
  logic [1:0]  grant_reg;
  logic [1:0]  done_reg;
  logic        blank_reg;
  logic [31:0] disp_score_reg;
  logic [31:0] disp_time_reg;
`ifdef DISP_SCHED_FLASH_EN
  logic [15:0] flash_cnt_reg;
`endif

  logic        tick;
  logic [15:0] ms_inc;
  logic        hold_end;
  logic        gap_end;
  logic [1:0]  winner;
  logic        launch;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign ms_inc   = ms_cnt_reg + 16'd1;
  assign hold_end = (HOLD_MS == 0) || (tick && ms_inc == 16'(HOLD_MS));
  assign gap_end  = (GAP_MS == 0) || (tick && ms_inc == 16'(GAP_MS));
  assign winner   = rr_pick(req, last_reg);
  // Requests are only looked at while idle or at the very end of a gap.
  assign launch   = (|req) && ((state_reg == NORMAL) || (state_reg == GAP && gap_end));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= NORMAL;
      ms_cnt_reg     <= '0;
      last_reg       <= 1'b1;
      owner_reg      <= 1'b0;
      grant_reg      <= '0;
      done_reg       <= '0;
      blank_reg      <= 1'b0;
      disp_score_reg <= '0;
      disp_time_reg  <= '0;
`ifdef DISP_SCHED_FLASH_EN
      flash_cnt_reg  <= '0;
`endif
    end else begin
      grant_reg <= '0;
      done_reg  <= '0;
      if (launch) begin
        state_reg      <= MSG;
        ms_cnt_reg     <= '0;
        owner_reg      <= winner[1];
        last_reg       <= winner[1];
        grant_reg      <= winner;
        blank_reg      <= 1'b0;
        disp_score_reg <= winner[1] ? msg1_score : msg0_score;
        disp_time_reg  <= winner[1] ? msg1_time : msg0_time;
`ifdef DISP_SCHED_FLASH_EN
        flash_cnt_reg  <= '0;
`endif
      end else begin
        case (state_reg)
          NORMAL: begin
            disp_score_reg <= score;
            disp_time_reg  <= total_time;
            blank_reg      <= 1'b0;
          end
          MSG: begin
            if (hold_end) begin
              state_reg  <= GAP;
              ms_cnt_reg <= '0;
              done_reg   <= owner_reg ? 2'b10 : 2'b01;
              blank_reg  <= 1'b1;
            end else if (tick) begin
              ms_cnt_reg <= ms_inc;
`ifdef DISP_SCHED_FLASH_EN
              if (flash_cnt_reg == 16'(FLASH_MS - 1)) begin
                flash_cnt_reg <= '0;
                blank_reg     <= ~blank_reg;
              end else begin
                flash_cnt_reg <= flash_cnt_reg + 16'd1;
              end
`endif
            end
          end
          GAP: begin
            if (gap_end) begin
              // No request pending at expiry: back to live values.
              state_reg      <= NORMAL;
              ms_cnt_reg     <= '0;
              blank_reg      <= 1'b0;
              disp_score_reg <= score;
              disp_time_reg  <= total_time;
            end else if (tick) begin
              ms_cnt_reg <= ms_inc;
            end
          end
          default: begin
            state_reg  <= NORMAL;
            ms_cnt_reg <= '0;
          end
        endcase
      end
    end
  end

  assign grant      = grant_reg;
  assign done       = done_reg;
  assign blank      = blank_reg;
  assign disp_score = disp_score_reg;
  assign disp_time  = disp_time_reg;

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: per-cycle model built from tick-edge
// arithmetic plus directed scenarios with literal expectations.
module tb_disp_sched;

  localparam int TD = 10;
  localparam int HM = 5;
  localparam int GM = 2;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] score = '0, total_time = '0;
  logic [1:0]  req = '0;
  logic [31:0] m0s = '0, m0t = '0, m1s = '0, m1t = '0;
  logic [1:0]  grant, done;
  logic [31:0] disp_score, disp_time;
  logic        blank;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  disp_sched #(.TICK_DIV(TD), .HOLD_MS(HM), .GAP_MS(GM)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .score      (score),
    .total_time (total_time),
    .req        (req),
    .msg0_score (m0s),
    .msg0_time  (m0t),
    .msg1_score (m1s),
    .msg1_time  (m1t),
    .grant      (grant),
    .done       (done),
    .disp_score (disp_score),
    .disp_time  (disp_time),
    .blank      (blank)
  );

  // ---------------- behavioural model ----------------
  typedef enum {IDLE, SHOWING, BLANKING} ph_t;
  int         e = 0;          // edges since reset release; tick edges are multiples of TD
  ph_t        ph = IDLE;
  int         t_end = 0;
  int         owner = 0;
  bit         last = 1'b1;
  bit         go;
  logic [1:0] exp_grant = '0, exp_done = '0;
  logic       exp_blank = 1'b0;
  logic [31:0] exp_ds = '0, exp_dt = '0;
  bit         disp_care = 1'b1;

  // Edge on which the n-th millisecond boundary after edge 'from' lands.
  function automatic int nth_tick(input int from, input int n);
    if (n == 0) return from + 1;
    return (from / TD + n) * TD;
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; ph = IDLE; last = 1'b1; owner = 0;
      exp_grant = '0; exp_done = '0; exp_blank = 1'b0;
      exp_ds = '0; exp_dt = '0; disp_care = 1'b1;
    end else begin
      e++;
      exp_grant = '0;
      exp_done  = '0;
      go = 1'b0;
      case (ph)
        IDLE: go = (req != 2'b00);
        SHOWING: if (e == t_end) begin
          exp_done  = (owner == 1) ? 2'b10 : 2'b01;
          exp_blank = 1'b1;
          disp_care = 1'b0;
          ph        = BLANKING;
          t_end     = nth_tick(e, GM);
        end
        BLANKING: if (e == t_end) begin
          go = (req != 2'b00);
          if (!go) ph = IDLE;
        end
        default: ;
      endcase
      if (go) begin
        owner     = (req == 2'b11) ? (last ? 0 : 1) : (req[1] ? 1 : 0);
        last      = (owner == 1);
        exp_grant = (owner == 1) ? 2'b10 : 2'b01;
        exp_ds    = (owner == 1) ? m1s : m0s;
        exp_dt    = (owner == 1) ? m1t : m0t;
        exp_blank = 1'b0;
        disp_care = 1'b1;
        ph        = SHOWING;
        t_end     = nth_tick(e, HM);
      end else if (ph == IDLE) begin
        exp_ds    = score;
        exp_dt    = total_time;
        exp_blank = 1'b0;
        disp_care = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, expv, e);
  endtask

  // Compare against the model on every post-reset cycle.
  always @(negedge clock) begin
    if (rst_n && e > 0) begin
      chk("grant", {30'd0, grant}, {30'd0, exp_grant});
      chk("done", {30'd0, done}, {30'd0, exp_done});
      chk("blank", {31'd0, blank}, {31'd0, exp_blank});
      if (disp_care) begin
        chk("disp_score", disp_score, exp_ds);
        chk("disp_time", disp_time, exp_dt);
      end
    end
  end

  task automatic nxt();
    @(negedge clock);
  endtask

`ifdef DISP_SCHED_FLASH_EN
  logic [1:0]  req_f = '0;
  logic [1:0]  grant_f, done_f;
  logic [31:0] ds_f, dt_f;
  logic        blank_f;

  disp_sched #(.TICK_DIV(TD), .HOLD_MS(600), .GAP_MS(GM)) dut_f (
    .clock      (clock),
    .rst_n      (rst_n),
    .score      (score),
    .total_time (total_time),
    .req        (req_f),
    .msg0_score (m0s),
    .msg0_time  (m0t),
    .msg1_score (m1s),
    .msg1_time  (m1t),
    .grant      (grant_f),
    .done       (done_f),
    .disp_score (ds_f),
    .disp_time  (dt_f),
    .blank      (blank_f)
  );
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gedge, cnt, ndone, g0, g1, d0, d1;
    logic [1:0] gq[$];
    logic [1:0] dq[$];

    // Reset state
    repeat (3) nxt();
    #1;
    chk("rst_grant", {30'd0, grant}, 0);
    chk("rst_done", {30'd0, done}, 0);
    chk("rst_blank", {31'd0, blank}, 0);
    chk("rst_disp_score", disp_score, 0);
    chk("rst_disp_time", disp_time, 0);

    // Live pass-through
    score = 123; total_time = 4567;
    #1 rst_n = 1'b1;
    nxt();
    chk("t1_disp_score", disp_score, 123);
    chk("t1_disp_time", disp_time, 4567);
    chk("t1_blank", {31'd0, blank}, 0);

    // Single message from requester 0, granted on a ms boundary
    for (int i = 0; i < 2 * TD && (e % TD) != TD - 1; i++) nxt();
    m0s = 999; m0t = 42; req = 2'b01;
    nxt();
    chk("t2_grant", {30'd0, grant}, 1);
    chk("t2_disp", disp_score, 999);
    gedge = e;
    req = 2'b00;
    for (int i = 0; i < 200 && done == 2'b00; i++) nxt();
    chk("t2_done", {30'd0, done}, 1);
    chk("t2_hold_cycles", e - gedge, 50);
    cnt = 0;
    for (int i = 0; i < 100 && blank; i++) begin cnt++; nxt(); end
    chk("t2_gap_cycles", cnt, 20);
    chk("t2_back_normal", disp_score, 123);

    // Both requesting out of reset
    #2 rst_n = 1'b0;
    req = 2'b11; m1s = 777; m1t = 88;
    nxt(); nxt();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 400 && dq.size() < 2; i++) begin
      nxt();
      if (grant != 2'b00) begin gq.push_back(grant); req = req & ~grant; end
      if (done != 2'b00) dq.push_back(done);
    end
    chk("t3_ngrants", gq.size(), 2);
    chk("t3_ndones", dq.size(), 2);
    g0 = (gq.size() > 0) ? int'(gq[0]) : 0;
    g1 = (gq.size() > 1) ? int'(gq[1]) : 0;
    d0 = (dq.size() > 0) ? int'(dq[0]) : 0;
    d1 = (dq.size() > 1) ? int'(dq[1]) : 0;
    chk("t3_grant_first", g0, 1);
    chk("t3_grant_second", g1, 2);
    chk("t3_done_first", d0, 1);
    chk("t3_done_second", d1, 2);
    req = 2'b00;
    for (int i = 0; i < 100 && blank; i++) nxt();

    // Requester 0 held: re-served alone, then loses to a newly pending requester 1
    req = 2'b01;
    for (int i = 0; i < 50 && grant == 2'b00; i++) nxt();
    chk("t4_first", {30'd0, grant}, 1);
    nxt();
    for (int i = 0; i < 200 && grant == 2'b00; i++) nxt();
    chk("t4_reserve", {30'd0, grant}, 1);
    repeat (20) nxt();
    req = 2'b11;
    nxt();
    for (int i = 0; i < 200 && grant == 2'b00; i++) nxt();
    chk("t4_rr_other", {30'd0, grant}, 2);
    req = 2'b00;
    repeat (100) nxt();

    // Reset 30 cycles into a message
    req = 2'b01; m0s = 31; m0t = 32;
    for (int i = 0; i < 50 && grant == 2'b00; i++) nxt();
    chk("t5_grant", {30'd0, grant}, 1);
    req = 2'b00;
    repeat (30) nxt();
    chk("t5_in_msg", disp_score, 31);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_disp_score", disp_score, 0);
    chk("t5_rst_disp_time", disp_time, 0);
    chk("t5_rst_blank", {31'd0, blank}, 0);
    chk("t5_rst_done", {30'd0, done}, 0);
    score = 55;
    repeat (3) nxt();
    #2 rst_n = 1'b1;
    nxt();
    chk("t5_first_pass", disp_score, 55);
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      nxt();
      if (done != 2'b00) ndone++;
    end
    chk("t5_no_done", ndone, 0);

`ifdef DISP_SCHED_FLASH_EN
    begin
      int t1, t2;
      req_f = 2'b01;
      for (int i = 0; i < 50 && grant_f == 2'b00; i++) nxt();
      chk("fl_grant", {30'd0, grant_f}, 1);
      req_f = 2'b00;
      t1 = (e / TD + 250) * TD;
      t2 = (e / TD + 500) * TD;
      for (int i = 0; i < 8000 && e < t1 - 1; i++) nxt();
      chk("fl_before_250", {31'd0, blank_f}, 0);
      nxt();
      chk("fl_at_250", {31'd0, blank_f}, 1);
      for (int i = 0; i < 8000 && e < t2 - 1; i++) nxt();
      chk("fl_before_500", {31'd0, blank_f}, 1);
      nxt();
      chk("fl_at_500", {31'd0, blank_f}, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
